memory: RTL and testbench
=========================

MEMORY -- requirements
Module: memory

Interface
REQ-001 Parameters: none; address map and widths fixed by shared package constants.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 address  input  16  word address from CPU.
REQ-005 load  input  1  write enable; 1 = write `in` to `address` at next rising edge.
REQ-006 in  input  16  write data (signed two's-complement word, treated as raw bits).
REQ-007 out  output  16  read data for `address`.
REQ-008 btn  input  1  external push-button, asynchronous to clk.
REQ-009 led  output  1  external LED drive, registered.

Function
REQ-010 Address map:
- 0x0000-0x1FFF: RAM, 8192 x 16.
- 0x2000: BTN, read-only.
- 0x2001: LED, read/write.
- 0x2002-0xFFFF: unmapped.
REQ-011 Read is combinational, zero latency: `out` follows `address` and stored contents with no clock.
REQ-012 RAM write: when load=1 and address<0x2000, mem[address[12:0]] <= in at the rising edge; `out` shows the new value after that edge.
REQ-013 RAM read returns the full 16-bit stored word, sign bits preserved (e.g. -1 reads 0xFFFF).
REQ-014 LED write: when load=1 and address=0x2001, led register <= in[0] at the rising edge; in[15:1] ignored.
REQ-015 LED read: address=0x2001 returns {15'b0, led}.
REQ-016 BTN read: address=0x2000 returns {15'b0, btn_sync}.
- btn_sync is btn passed through a 2-flop synchronizer, so it lags btn by 2 rising edges.
REQ-017 Writes to 0x2000 (load=1) are ignored and change no state.
REQ-018 Unmapped reads return 0x0000; unmapped writes are ignored.
REQ-019 load=0 modifies nothing, whatever `address` and `in` are.
REQ-020 Address decode is exclusive: each write affects at most one target; RAM is never aliased into I/O space.
REQ-021 Same-cycle write and read of one location: `out` shows the old value before the edge and the new value after it.

Reset
REQ-022 rst_n=0 asynchronously clears the led register and both synchronizer flops to 0.
REQ-023 While rst_n=0:
- writes are blocked;
- out at 0x2000/0x2001 reads 0x0000.
REQ-024 RAM contents are not reset; they are undefined until first written.
REQ-025 Deassertion of rst_n is sampled synchronously; normal writes resume at the first rising edge with rst_n=1.

Structure
REQ-026 Shared package memory_pkg holds:
- RAM_BASE=0x0000, RAM_WORDS=8192;
- BTN_ADDR=0x2000, LED_ADDR=0x2001;
- DATA_W=16, ADDR_W=16.
REQ-027 One sub-module ram_8k holds the RAM: 8192x16, synchronous write, asynchronous read, ports clk/we/addr[12:0]/din/dout.
REQ-028 Top level holds:
- address decode;
- LED register;
- BTN synchronizer;
- output mux.

Verification
REQ-029 Reset, then address=0x2001, load=0 -> out=0x0000, led=0.
REQ-030 load=1, address=0x2001, in=1, one edge -> led=1, out=0x0001. Then load=1, in=0x0002, one edge -> led=0.
REQ-031 load=1, address=0x0000, in=-1, one edge -> out=0xFFFF. Then load=0, in=9999, two edges -> out stays 0xFFFF.
REQ-032 load=0, address=0x2000, in=12345 -> no state change. Raise btn; out=0x0000 until 2 edges, then 0x0001.
REQ-033 Write 0x1234 to 0x1FFF and 0x5678 to 0x2002 -> 0x1FFF reads 0x1234, 0x2002 reads 0x0000, led unchanged.
REQ-034 Assert rst_n=0 mid-cycle with led=1 -> led=0 immediately, without a clock edge; the RAM word at 0x0000 still reads 0xFFFF.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared address map, widths and decode helper for the memory block.
// Imported by the interface, the RAM and the top level.
package memory_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int RAM_WORDS = 8192;
  localparam int RAM_AW    = 13;

  localparam logic [ADDR_W-1:0] RAM_BASE = 16'h0000;
  localparam logic [ADDR_W-1:0] BTN_ADDR = 16'h2000;
  localparam logic [ADDR_W-1:0] LED_ADDR = 16'h2001;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_BTN,
    SEL_LED,
    SEL_NONE
  } sel_e;

  // Exclusive decode: exactly one target per address.
  function automatic sel_e decode(
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W-1:0] off;
    sel_e s;
    off = a - RAM_BASE;
    s   = SEL_NONE;
    unique case (1'b1)
      (off < ADDR_W'(RAM_WORDS)): s = SEL_RAM;
      (a == BTN_ADDR):            s = SEL_BTN;
      (a == LED_ADDR):            s = SEL_LED;
      default:                    s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/memory_if.sv
// CPU-side bus of the memory block: address, write strobe,
// write data and combinational read data.
interface memory_if;
  import memory_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              load;
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out;

  modport master (
    output address,
    output load,
    output in,
    input  out
  );

  modport slave (
    input  address,
    input  load,
    input  in,
    output out
  );

endinterface

// File: rtl/memory_ram_8k.sv
// 8192 x 16 RAM: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module ram_8k
  import memory_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
    end
  end

  assign dout = mem_q[addr];

endmodule

// File: rtl/memory.sv
// Memory-mapped RAM + button/LED I/O for the CPU.
// Decode, LED register, button synchronizer and read mux.
module memory
  import memory_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  memory_if.slave   bus,
  input  logic      btn,
  output logic      led
);

  sel_e              sel;
  logic              ram_we;
  logic              led_we;
  logic [DATA_W-1:0] ram_dout;

  logic led_q, led_d;
  logic sync1_q, sync2_q;

  assign sel = decode(bus.address);

  // Writes are suppressed while reset is held.
  assign ram_we = bus.load & rst_n & (sel == SEL_RAM);
  assign led_we = bus.load & rst_n & (sel == SEL_LED);

  ram_8k u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (bus.address[RAM_AW-1:0]),
    .din  (bus.in),
    .dout (ram_dout)
  );

  assign led_d = led_we ? bus.in[0] : led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q   <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      led_q   <= led_d;
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    bus.out = '0;
    unique case (sel)
      SEL_RAM:  bus.out = ram_dout;
      SEL_BTN:  bus.out = {{(DATA_W-1){1'b0}}, sync2_q};
      SEL_LED:  bus.out = {{(DATA_W-1){1'b0}}, led_q};
      default:  bus.out = '0;
    endcase
  end

  assign led = led_q;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: scenario tasks feed a
// scoreboard queue of expected read data.
module tb_memory;

  logic clk;
  logic rst_n;
  logic btn;
  logic led;

  memory_if bus ();

  memory dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .btn   (btn),
    .led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] sb_q [$];
  logic [15:0] exp;

  task automatic drive(
    input logic [15:0] a,
    input logic        l,
    input logic [15:0] d
  );
    @(negedge clk);
    bus.address = a;
    bus.load    = l;
    bus.in      = d;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 1'b0;
    bus.address = 16'h2001;
    bus.load    = 1'b0;
    bus.in      = 16'h0000;
    repeat (2) @(posedge clk);
    drive(16'h2001, 1'b0, 16'h0000);
    sb_q.push_back(16'h0000);
    #1;
    exp = sb_q.pop_front();
    n_checks++;
    if (bus.out !== exp) begin
      n_fail++;
      $display("FAIL reset_led_read out=%h exp=%h", bus.out, exp);
    end
    n_checks++;
    if (led !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_led out=%b exp=0", led);
    end
    @(negedge clk);
    rst_n = 1'b1;
    edge1();
    sb_q.push_back(16'h0000);
    exp = sb_q.pop_front();
    n_checks++;
    if (bus.out !== exp || led !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset out=%h led=%b exp=%h/0",
               bus.out, led, exp);
    end
  endtask

  task automatic test_led();
    drive(16'h2001, 1'b1, 16'h0001);
    sb_q.push_back(16'h0001);
    edge1();
    exp = sb_q.pop_front();
    n_checks++;
    if (bus.out !== exp || led !== 1'b1) begin
      n_fail++;
      $display("FAIL led_set out=%h led=%b exp=%h/1",
               bus.out, led, exp);
    end
    drive(16'h2001, 1'b1, 16'h0002);
    sb_q.push_back(16'h0000);
    edge1();
    exp = sb_q.pop_front();
    n_checks++;
    if (bus.out !== exp || led !== 1'b0) begin
      n_fail++;
      $display("FAIL led_bit0_only out=%h led=%b exp=%h/0",
               bus.out, led, exp);
    end
  endtask

  task automatic test_ram();
    drive(16'h0000, 1'b1, 16'hFFFF);
    sb_q.push_back(16'hFFFF);
    edge1();
    exp = sb_q.pop_front();
    n_checks++;
    if (bus.out !== exp) begin
      n_fail++;
      $display("FAIL ram_neg1 out=%h exp=%h", bus.out, exp);
    end
    drive(16'h0000, 1'b0, 16'd9999);
    sb_q.push_back(16'hFFFF);
    sb_q.push_back(16'hFFFF);
    for (int i = 0; i < 2; i++) begin
      edge1();
      exp = sb_q.pop_front();
      n_checks++;
      if (bus.out !== exp) begin
        n_fail++;
        $display("FAIL ram_noload[%0d] out=%h exp=%h",
                 i, bus.out, exp);
      end
    end
    // same-cycle write/read: old value before edge, new after
    drive(16'h0005, 1'b1, 16'h1111);
    edge1();
    drive(16'h0005, 1'b1, 16'h2222);
    sb_q.push_back(16'h1111);
    sb_q.push_back(16'h2222);
    #1;
    exp = sb_q.pop_front();
    n_checks++;
    if (bus.out !== exp) begin
      n_fail++;
      $display("FAIL rw_before out=%h exp=%h", bus.out, exp);
    end
    edge1();
    exp = sb_q.pop_front();
    n_checks++;
    if (bus.out !== exp) begin
      n_fail++;
      $display("FAIL rw_after out=%h exp=%h", bus.out, exp);
    end
  endtask

  task automatic test_btn();
    drive(16'h2000, 1'b1, 16'd12345);
    edge1();
    n_checks++;
    if (bus.out !== 16'h0000 || led !== 1'b0) begin
      n_fail++;
      $display("FAIL btn_write out=%h led=%b exp=0000/0",
               bus.out, led);
    end
    drive(16'h2000, 1'b0, 16'd12345);
    btn = 1'b1;
    sb_q.push_back(16'h0000);
    sb_q.push_back(16'h0000);
    sb_q.push_back(16'h0001);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) edge1();
      exp = sb_q.pop_front();
      n_checks++;
      if (bus.out !== exp) begin
        n_fail++;
        $display("FAIL btn_sync[%0d] out=%h exp=%h",
                 i, bus.out, exp);
      end
    end
  endtask

  task automatic test_boundary();
    drive(16'h2001, 1'b1, 16'h0001);
    edge1();
    drive(16'h1FFF, 1'b1, 16'h1234);
    edge1();
    drive(16'h2002, 1'b1, 16'h5678);
    edge1();
    drive(16'hFFFF, 1'b1, 16'h9ABC);
    edge1();
    sb_q.push_back(16'h1234);
    sb_q.push_back(16'h0000);
    sb_q.push_back(16'h0000);
    sb_q.push_back(16'hFFFF);
    sb_q.push_back(16'h0001);
    foreach (sb_q[i]) begin
    end
    begin
      logic [15:0] addrs [5];
      addrs = '{16'h1FFF, 16'h2002, 16'hFFFF,
                16'h0000, 16'h2001};
      for (int i = 0; i < 5; i++) begin
        drive(addrs[i], 1'b0, 16'h0000);
        #1;
        exp = sb_q.pop_front();
        n_checks++;
        if (bus.out !== exp) begin
          n_fail++;
          $display("FAIL boundary@%h out=%h exp=%h",
                   addrs[i], bus.out, exp);
        end
      end
    end
    n_checks++;
    if (led !== 1'b1) begin
      n_fail++;
      $display("FAIL boundary_led out=%b exp=1", led);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (led !== 1'b0) begin
      n_fail++;
      $display("FAIL async_led out=%b exp=0", led);
    end
    bus.address = 16'h0000;
    bus.load    = 1'b1;
    bus.in      = 16'h1111;
    #1;
    sb_q.push_back(16'hFFFF);
    sb_q.push_back(16'hFFFF);
    exp = sb_q.pop_front();
    n_checks++;
    if (bus.out !== exp) begin
      n_fail++;
      $display("FAIL reset_ram_keep out=%h exp=%h", bus.out, exp);
    end
    edge1();
    exp = sb_q.pop_front();
    n_checks++;
    if (bus.out !== exp) begin
      n_fail++;
      $display("FAIL reset_wr_block out=%h exp=%h", bus.out, exp);
    end
    drive(16'h2000, 1'b0, 16'h0000);
    #1;
    n_checks++;
    if (bus.out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_btn_read out=%h exp=0000", bus.out);
    end
    rst_n = 1'b1;
    drive(16'h0000, 1'b1, 16'h4321);
    sb_q.push_back(16'h4321);
    edge1();
    exp = sb_q.pop_front();
    n_checks++;
    if (bus.out !== exp) begin
      n_fail++;
      $display("FAIL write_resume out=%h exp=%h", bus.out, exp);
    end
  endtask

  initial begin
    test_reset();
    test_led();
    test_ram();
    test_btn();
    test_boundary();
    test_async_reset();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left size=%0d exp=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
